// File: rtl/inv_solver_pkg.sv
// Shared types for the shift/compare invertibility witness engine and its checker.
package inv_solver_pkg;

    typedef enum logic [1:0] {
        OP_LSHR = 2'd0,
        OP_ASHR = 2'd1,
        OP_SHL  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic {
        CMP_SGT = 1'b0,
        CMP_UGT = 1'b1
    } cmp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter width able to hold every shift amount 0..w inclusive.
    function automatic int kw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bv_shift_cmp.sv
// Combinational evaluation of (s OP k) CMP t for one candidate shift amount k.
module bv_shift_cmp
    import inv_solver_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int KW    = kw_of(WIDTH)
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  logic [KW-1:0]    k,
    input  op_e              op,
    input  cmp_e             cmp,
    output logic             hit
);

    localparam logic [KW-1:0] K_MAX = KW'(WIDTH);

    logic [WIDTH-1:0] w_lshr [0:WIDTH];
    logic [WIDTH-1:0] w_ashr [0:WIDTH];
    logic [WIDTH-1:0] w_shl  [0:WIDTH];
    logic [KW-1:0]    w_kc;
    logic [WIDTH-1:0] w_r;
    logic             w_valid_op;

    // Every amount at or beyond WIDTH behaves like WIDTH, so one extra slot covers them all.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_amt
            if (gi < WIDTH) begin : g_in_range
                assign w_lshr[gi] = s >> gi;
                assign w_ashr[gi] = $signed(s) >>> gi;
                assign w_shl[gi]  = s << gi;
            end else begin : g_saturated
                assign w_lshr[gi] = '0;
                assign w_ashr[gi] = {WIDTH{s[WIDTH-1]}};
                assign w_shl[gi]  = '0;
            end
        end
    endgenerate

    assign w_kc = (k > K_MAX) ? K_MAX : k;

    always_comb begin
        w_r        = '0;
        w_valid_op = 1'b1;
        case (op)
            OP_LSHR: w_r = w_lshr[w_kc];
            OP_ASHR: w_r = w_ashr[w_kc];
            OP_SHL:  w_r = w_shl[w_kc];
            default: w_valid_op = 1'b0;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        if (w_valid_op) begin
            if (cmp == CMP_SGT) begin
                hit = $signed(w_r) > $signed(t);
            end else begin
                hit = w_r > t;
            end
        end
    end

endmodule

// File: rtl/inv_shift_cmp_solver.sv
// Handshaked engine returning the smallest shift amount x with (s OP x) CMP t, or unsat.
module inv_shift_cmp_solver
    import inv_solver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  logic [1:0]       op,
    input  logic             cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             sat,
    output logic             err
);

    localparam int            KW    = kw_of(WIDTH);
    localparam logic [KW-1:0] K_MAX = KW'(WIDTH);

    state_e           r_state;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    op_e              r_op;
    cmp_e             r_cmp;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_x;
    logic             r_sat;
    logic             r_err;
    logic             r_out_valid;
    logic             w_hit;

    bv_shift_cmp #(
        .WIDTH (WIDTH)
    ) u_eval (
        .s   (r_s),
        .t   (r_t),
        .k   (r_k),
        .op  (r_op),
        .cmp (r_cmp),
        .hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_t         <= '0;
            r_op        <= OP_LSHR;
            r_cmp       <= CMP_SGT;
            r_k         <= '0;
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s   <= s;
                        r_t   <= t;
                        r_op  <= op_e'(op);
                        r_cmp <= cmp_e'(cmp);
                        r_k   <= '0;
                        if (op_e'(op) == OP_RSVD) begin
                            r_x         <= '0;
                            r_sat       <= 1'b0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // k == WIDTH stands in for every larger amount, so it is the last candidate.
                    if (w_hit) begin
                        r_x         <= r_k;
                        r_sat       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_k == K_MAX) begin
                        r_x         <= '0;
                        r_sat       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign x         = WIDTH'(r_x);
    assign sat       = r_sat;
    assign err       = r_err;

endmodule
